ram_8_16_rr_arbiter: RTL and testbench
======================================

# ram_8_16_rr_arbiter

Single-clock round-robin arbiter that shares one 8x16 RAM between two requesters. Each requester issues read or write commands over a req/gnt handshake. The arbiter drives the RAM write and read ports and returns read data to the requester that issued the read, tagged with a one-cycle valid pulse. It sits between two client blocks and the 8x16 RAM, with both RAM clocks tied to `clk`.

## Interface

**Parameters**
- `ADDR_W`, 3: RAM address width (8 words).
- `DATA_W`, 16: RAM data width.
- `RD_LAT`, 1: RAM read latency in `clk` cycles, counted from the `ram_re` cycle to the `ram_data_out` valid cycle. Legal range 1..4.

**Ports**
- Clock and reset: one clock, `clk`. Reset is `clr`, asynchronous and active-high.
- `clk`  in  1  system clock; all state is updated on the rising edge.
- `clr`  in  1  asynchronous active-high clear.
- `req0`, `req1`  in  1  access request, held high until the matching `gnt`.
- `wr0`, `wr1`  in  1  1 = write, 0 = read; valid while `req` is high.
- `addr0`, `addr1`  in  ADDR_W  word address.
- `wdata0`, `wdata1`  in  DATA_W  write data.
- `gnt0`, `gnt1`  out  1  one-cycle grant pulse; the command is issued to the RAM in this cycle.
- `rvalid0`, `rvalid1`  out  1  one-cycle read-return pulse.
- `rdata0`, `rdata1`  out  DATA_W  read data; holds its value until the next `rvalid` on that port.
- `ram_we`, `ram_re`  out  1  RAM write and read enables.
- `ram_wr_addr`, `ram_rd_addr`  out  ADDR_W  RAM addresses.
- `ram_data_in`  out  DATA_W  RAM write data.
- `ram_data_out`  in  DATA_W  RAM read data.

## Operation

**State machine:** two states, `IDLE` and `ISSUE`.
- **`IDLE`**
  - If any `req` is high, select a winner, latch its `wr`/`addr`/`wdata` and the winner id, and move to `ISSUE`.
  - Otherwise stay in `IDLE`.
- **`ISSUE`**
  - Assert `gnt` of the winner.
  - Drive either `ram_we` with `ram_wr_addr`/`ram_data_in`, or `ram_re` with `ram_rd_addr`, from the latched command.
  - Return to `IDLE` unconditionally.
  - Requests are not sampled in `ISSUE`, so a `req` still high during its own grant cycle is never granted twice.

**Winner selection:**
- Only one `req` high: that requester wins.
- Both high: the requester not named by `last_gnt` wins.
- `last_gnt` updates to the winner on the `IDLE`→`ISSUE` transition.
- `last_gnt` resets to 1, so requester 0 wins the first tie.

**Read return:**
- Every read is tagged with the winner id into a valid/id pipeline RD_LAT+1 stages deep.
- When the tag emerges, `ram_data_out` is captured into `rdata<id>` and `rvalid<id>` pulses.

**Writes:**
- A write produces no return.
- The write is committed to the RAM at the end of its `ISSUE` cycle.
- A later read of the same address returns the new data.

**Boundary conditions:**
- Address 7 followed by address 0 needs no special handling; addresses are used as-is.
- Reads in flight continue to return while new commands issue. The return order equals the issue order.
- `rvalid0` and `rvalid1` are never high in the same cycle.

**Reset, at any time including mid-operation:**
- State goes to `IDLE` and `last_gnt` to 1.
- All `gnt`, `rvalid`, `ram_we` and `ram_re` go to 0.
- All address and data outputs, including `rdata0`/`rdata1`, go to 0.
- The read pipeline is flushed, so in-flight reads are dropped and produce no `rvalid`.

## Timing

- `req` sampled high in `IDLE` in cycle N: `gnt` and the RAM command occur in cycle N+1.
- Maximum throughput is one access per 2 cycles.
- Read granted in cycle G: `ram_data_out` is valid in cycle G+RD_LAT and `rvalid` is high in cycle G+RD_LAT+1. With RD_LAT=1, `rvalid` comes 2 cycles after `gnt`.
- Requester handshake:
  - The requester may drop `req` or change its command in the cycle after `gnt`.
  - If `req` is dropped before a grant, the request is withdrawn and no grant is owed.
- All outputs are registered. No combinational path exists from `req` to `gnt`.

## Structure

- Shared package `ram_arb_pkg`:
  - `ADDR_W` and `DATA_W` defaults.
  - State encoding `IDLE`/`ISSUE`.
  - Requester id width (1 bit).
- Sub-module `rd_tag_pipe`: parameterised shift register of {valid, id} with depth RD_LAT+1 and an asynchronous `clr` flush.
- Arbitration, the FSM and the output registers stay in the top level.

## Test plan

- **Reset:** `clr` held high for 50 ns.
  - All outputs read 0.
  - The first tie after release grants requester 0.
- **Single writer:** `req0` writes 0x000A to addr 3.
  - `gnt0` one cycle later with `ram_we`=1, `ram_wr_addr`=3, `ram_data_in`=0x000A.
  - Then `req0` reads addr 3: `rvalid0` 2 cycles after `gnt0` with `rdata0`=0x000A (RD_LAT=1).
- **Contention:** both requesters hold `req` for 4 grants.
  - Grants alternate 0,1,0,1, spaced 2 cycles apart.
  - `gnt0` and `gnt1` are never high together.
- **Interleaved reads:** addr 0..7 preloaded with 0x0010+i; req0 reads addr 7 and req1 reads addr 0 back-to-back.
  - `rvalid0` returns 0x0017, then `rvalid1` returns 0x0010, in grant order.
  - `rdata1` is unchanged while `rvalid0` fires.
- **Reset mid-read:** assert `clr` in the cycle after a read `gnt`.
  - No `rvalid` appears.
  - `rdata` reads 0.
  - Requester 0 wins the next tie.
- **RD_LAT=3:** a read granted in cycle G gives `rvalid` in cycle G+4 with correct data.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-requester 8x16 RAM arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package ram_arb_pkg;

    localparam int ADDR_W_DEF = 3;
    localparam int DATA_W_DEF = 16;
    localparam int ID_W       = 1;

    typedef logic [ID_W-1:0] id_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Shift register of {valid, requester id} that follows each read through the RAM.
// Latency: DEPTH cycles from in_vld to out_vld.
// Backpressure: none; one entry shifts every cycle, clr flushes every stage at once.
//
// Ports: clk, clr (async flush), in_vld/in_id (tag entering), out_vld/out_id (tag leaving).
module rd_tag_pipe
    import ram_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic in_vld,
    input  id_t  in_id,
    output logic out_vld,
    output id_t  out_id
);

    logic [DEPTH-1:0] vld_q;
    id_t              id_q [DEPTH];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                id_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_vld;
            id_q[0]  <= in_id;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                id_q[i]  <= id_q[i-1];
            end
        end
    end

    assign out_vld = vld_q[DEPTH-1];
    assign out_id  = id_q[DEPTH-1];

endmodule

// File: rtl/ram_8_16_rr_arbiter.sv
// Round-robin arbiter sharing one 8x16 RAM between two requesters, with tagged read return.
// Latency: gnt + RAM command one cycle after req is sampled; rvalid RD_LAT+1 cycles after gnt.
// Backpressure: req is held until gnt; at most one access every 2 cycles.
//
// Ports: clk, clr (async active-high); req/wr/addr/wdata per requester in, gnt per requester out;
//        rvalid/rdata per requester out; ram_we/ram_re/ram_wr_addr/ram_rd_addr/ram_data_in to the
//        RAM, ram_data_out from the RAM. All outputs are registered.
module ram_8_16_rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 1            // legal range 1..4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              req0,
    input  logic              req1,
    input  logic              wr0,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              ram_we,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [ADDR_W-1:0] ram_rd_addr,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out
);

    state_t state;
    id_t    last_gnt;

    // Winner of the current IDLE cycle; only acted on when state is IDLE.
    id_t               win;
    logic              win_wr;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              any_req;

    always_comb begin
        any_req = req0 | req1;
        if (req0 && req1) begin
            win = ~last_gnt;        // tie goes to whoever was not served last
        end else if (req1) begin
            win = 1'b1;
        end else begin
            win = 1'b0;
        end
        win_wr    = win ? wr1    : wr0;
        win_addr  = win ? addr1  : addr0;
        win_wdata = win ? wdata1 : wdata0;
    end

    // The FSM registers the RAM command directly into the output flops, so the
    // command and gnt appear together in the ISSUE cycle.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state       <= IDLE;
            last_gnt    <= 1'b1;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            ram_we      <= 1'b0;
            ram_re      <= 1'b0;
            ram_wr_addr <= '0;
            ram_rd_addr <= '0;
            ram_data_in <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state    <= ISSUE;
                        last_gnt <= win;
                        gnt0     <= (win == 1'b0);
                        gnt1     <= (win == 1'b1);
                        if (win_wr) begin
                            ram_we      <= 1'b1;
                            ram_wr_addr <= win_addr;
                            ram_data_in <= win_wdata;
                        end else begin
                            ram_re      <= 1'b1;
                            ram_rd_addr <= win_addr;
                        end
                    end
                end
                ISSUE: begin
                    // Requests are ignored here, so a req still high during its
                    // own grant cycle cannot be granted a second time.
                    state  <= IDLE;
                    gnt0   <= 1'b0;
                    gnt1   <= 1'b0;
                    ram_we <= 1'b0;
                    ram_re <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The tag is pushed alongside ram_re, so it reaches the last stage in the
    // cycle that ram_data_out is valid and the capture lands one cycle later.
    logic tag_push;
    logic tag_vld;
    id_t  tag_id;

    assign tag_push = (state == IDLE) && any_req && !win_wr;

    rd_tag_pipe #(
        .DEPTH (RD_LAT + 1)
    ) u_rd_tag_pipe (
        .clk     (clk),
        .clr     (clr),
        .in_vld  (tag_push),
        .in_id   (win),
        .out_vld (tag_vld),
        .out_id  (tag_id)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            if (tag_vld) begin
                if (tag_id == 1'b0) begin
                    rvalid0 <= 1'b1;
                    rdata0  <= ram_data_out;
                end else begin
                    rvalid1 <= 1'b1;
                    rdata1  <= ram_data_out;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_8_16_rr_arbiter.sv
// Directed bench for ram_8_16_rr_arbiter: one instance with RD_LAT=1, one with RD_LAT=3,
// each attached to a small behavioural RAM. Inputs change and outputs are sampled 1 ns
// after the rising edge.
module tb_ram_8_16_rr_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic clr;

    // Instance A: RD_LAT = 1
    logic        req0, req1, wr0, wr1;
    logic [2:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [15:0] rdata0, rdata1;
    logic        ram_we, ram_re;
    logic [2:0]  ram_wr_addr, ram_rd_addr;
    logic [15:0] ram_data_in, ram_data_out;

    // Instance B: RD_LAT = 3
    logic        b_req0, b_req1, b_wr0, b_wr1;
    logic [2:0]  b_addr0, b_addr1;
    logic [15:0] b_wdata0, b_wdata1;
    logic        b_gnt0, b_gnt1, b_rvalid0, b_rvalid1;
    logic [15:0] b_rdata0, b_rdata1;
    logic        b_ram_we, b_ram_re;
    logic [2:0]  b_ram_wr_addr, b_ram_rd_addr;
    logic [15:0] b_ram_data_in, b_ram_data_out;

    ram_8_16_rr_arbiter #(.ADDR_W(3), .DATA_W(16), .RD_LAT(1)) u_dut_a (
        .clk(clk), .clr(clr),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .ram_we(ram_we), .ram_re(ram_re),
        .ram_wr_addr(ram_wr_addr), .ram_rd_addr(ram_rd_addr),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
    );

    ram_8_16_rr_arbiter #(.ADDR_W(3), .DATA_W(16), .RD_LAT(3)) u_dut_b (
        .clk(clk), .clr(clr),
        .req0(b_req0), .req1(b_req1), .wr0(b_wr0), .wr1(b_wr1),
        .addr0(b_addr0), .addr1(b_addr1), .wdata0(b_wdata0), .wdata1(b_wdata1),
        .gnt0(b_gnt0), .gnt1(b_gnt1), .rvalid0(b_rvalid0), .rvalid1(b_rvalid1),
        .rdata0(b_rdata0), .rdata1(b_rdata1),
        .ram_we(b_ram_we), .ram_re(b_ram_re),
        .ram_wr_addr(b_ram_wr_addr), .ram_rd_addr(b_ram_rd_addr),
        .ram_data_in(b_ram_data_in), .ram_data_out(b_ram_data_out)
    );

    // Behavioural RAMs: write at the end of the we cycle, read data RD_LAT cycles after re.
    logic [15:0] mem_a [8];
    logic [15:0] rd_a;
    always @(posedge clk) begin
        if (ram_we) mem_a[ram_wr_addr] <= ram_data_in;
        if (ram_re) rd_a <= mem_a[ram_rd_addr];
    end
    assign ram_data_out = rd_a;

    logic [15:0] mem_b [8];
    logic [15:0] rd_b [3];
    always @(posedge clk) begin
        if (b_ram_we) mem_b[b_ram_wr_addr] <= b_ram_data_in;
        if (b_ram_re) rd_b[0] <= mem_b[b_ram_rd_addr];
        rd_b[1] <= rd_b[0];
        rd_b[2] <= rd_b[1];
    end
    assign b_ram_data_out = rd_b[2];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {gnt1,gnt0} for the 8 cycles after both requesters raise req.
    logic [1:0] cont_exp [8] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};

    initial begin
        clr = 1'b1;
        req0 = 0; req1 = 0; wr0 = 0; wr1 = 0; addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        b_req0 = 0; b_req1 = 0; b_wr0 = 0; b_wr1 = 0; b_addr0 = 0; b_addr1 = 0;
        b_wdata0 = 0; b_wdata1 = 0;

        // ---------------- reset held for 50 ns ----------------
        repeat (5) tick();
        chk("rst_gnt",     32'({gnt1, gnt0}), 32'd0);
        chk("rst_rvalid",  32'({rvalid1, rvalid0}), 32'd0);
        chk("rst_rdata0",  32'(rdata0), 32'd0);
        chk("rst_rdata1",  32'(rdata1), 32'd0);
        chk("rst_ram_en",  32'({ram_we, ram_re}), 32'd0);
        chk("rst_addrs",   32'({ram_wr_addr, ram_rd_addr}), 32'd0);
        chk("rst_data_in", 32'(ram_data_in), 32'd0);
        chk("rst_b_outs",  32'({b_gnt1, b_gnt0, b_rvalid1, b_rvalid0, b_ram_we, b_ram_re}), 32'd0);
        clr = 1'b0;
        tick();

        // ---------------- contention: first tie goes to 0, then alternate ----------------
        req0 = 1; wr0 = 1; addr0 = 3'd5; wdata0 = 16'h0055;
        req1 = 1; wr1 = 1; addr1 = 3'd6; wdata1 = 16'h0066;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("cont_gnt_c%0d", k + 1), 32'({gnt1, gnt0}), 32'(cont_exp[k]));
            chk("cont_gnt_excl", 32'(gnt0 & gnt1), 32'd0);
            if (k == 6) begin
                req0 = 0; req1 = 0;
            end
        end

        // ---------------- single writer then read-back ----------------
        req0 = 1; wr0 = 1; addr0 = 3'd3; wdata0 = 16'h000A;
        tick();
        chk("wr_gnt0",     32'({gnt1, gnt0}), 32'd1);
        chk("wr_ram_we",   32'({ram_we, ram_re}), 32'b10);
        chk("wr_addr",     32'(ram_wr_addr), 32'd3);
        chk("wr_data_in",  32'(ram_data_in), 32'h000A);
        req0 = 0;
        tick();
        req0 = 1; wr0 = 0; addr0 = 3'd3;
        tick();
        chk("rd_gnt0",     32'({gnt1, gnt0}), 32'd1);
        chk("rd_ram_re",   32'({ram_we, ram_re}), 32'b01);
        chk("rd_addr",     32'(ram_rd_addr), 32'd3);
        req0 = 0;
        tick();
        chk("rd_rvalid_g1", 32'({rvalid1, rvalid0}), 32'd0);
        tick();
        chk("rd_rvalid_g2", 32'({rvalid1, rvalid0}), 32'b01);
        chk("rd_rdata0",    32'(rdata0), 32'h000A);
        tick();
        chk("rd_rvalid_g3", 32'({rvalid1, rvalid0}), 32'd0);
        chk("rd_rdata0_hold", 32'(rdata0), 32'h000A);

        // ---------------- preload 0x0010+i through requester 1 ----------------
        for (int i = 0; i < 8; i++) begin
            req1 = 1; wr1 = 1; addr1 = 3'(i); wdata1 = 16'h0010 + 16'(i);
            tick();
            chk($sformatf("pre_gnt1_a%0d", i), 32'({gnt1, gnt0}), 32'b10);
            req1 = 0;
            tick();
        end

        // ---------------- interleaved reads: 0 reads addr 7, 1 reads addr 0 ----------------
        req0 = 1; wr0 = 0; addr0 = 3'd7;
        req1 = 1; wr1 = 0; addr1 = 3'd0;
        tick();
        chk("il_gnt_first", 32'({gnt1, gnt0}), 32'b01);
        chk("il_rd_addr7",  32'(ram_rd_addr), 32'd7);
        req0 = 0;
        tick();
        chk("il_idle_gnt",  32'({gnt1, gnt0}), 32'd0);
        tick();
        chk("il_gnt_second", 32'({gnt1, gnt0}), 32'b10);
        chk("il_rd_addr0",   32'(ram_rd_addr), 32'd0);
        chk("il_rvalid0",    32'({rvalid1, rvalid0}), 32'b01);
        chk("il_rdata0",     32'(rdata0), 32'h0017);
        chk("il_rdata1_held", 32'(rdata1), 32'h0000);
        req1 = 0;
        tick();
        chk("il_rvalid_gap", 32'({rvalid1, rvalid0}), 32'd0);
        tick();
        chk("il_rvalid1",    32'({rvalid1, rvalid0}), 32'b10);
        chk("il_rdata1",     32'(rdata1), 32'h0010);
        chk("il_rdata0_held", 32'(rdata0), 32'h0017);
        tick();

        // ---------------- reset mid-read ----------------
        req0 = 1; wr0 = 0; addr0 = 3'd2;
        tick();
        chk("mr_gnt0", 32'({gnt1, gnt0}), 32'b01);
        req0 = 0;
        tick();
        clr = 1'b1;
        #1;
        chk("mr_clr_rdata0", 32'(rdata0), 32'd0);
        chk("mr_clr_outs",   32'({gnt1, gnt0, rvalid1, rvalid0, ram_we, ram_re}), 32'd0);
        clr = 1'b0;
        tick();
        chk("mr_no_rvalid_a", 32'({rvalid1, rvalid0}), 32'd0);
        chk("mr_rdata0_zero", 32'(rdata0), 32'd0);
        tick();
        chk("mr_no_rvalid_b", 32'({rvalid1, rvalid0}), 32'd0);
        req0 = 1; wr0 = 1; addr0 = 3'd1; wdata0 = 16'h0101;
        req1 = 1; wr1 = 1; addr1 = 3'd1; wdata1 = 16'h0202;
        tick();
        chk("mr_tie_gnt0", 32'({gnt1, gnt0}), 32'b01);
        req0 = 0; req1 = 0;
        tick();

        // ---------------- RD_LAT = 3 on instance B ----------------
        b_req0 = 1; b_wr0 = 1; b_addr0 = 3'd4; b_wdata0 = 16'hBEEF;
        tick();
        chk("b_wr_gnt0", 32'({b_gnt1, b_gnt0}), 32'b01);
        b_req0 = 0;
        tick();
        b_req0 = 1; b_wr0 = 0; b_addr0 = 3'd4;
        tick();
        chk("b_rd_gnt0", 32'({b_gnt1, b_gnt0, b_ram_re}), 32'b011);
        b_req0 = 0;
        tick();
        tick();
        tick();
        chk("b_rvalid_g3", 32'({b_rvalid1, b_rvalid0}), 32'd0);
        tick();
        chk("b_rvalid_g4", 32'({b_rvalid1, b_rvalid0}), 32'b01);
        chk("b_rdata0",    32'(b_rdata0), 32'hBEEF);
        tick();
        chk("b_rvalid_g5", 32'({b_rvalid1, b_rvalid0}), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
